// File: rtl/c2h_pkg.sv
// Shared definitions for the card-to-host packet assembler: FSM states,
// descriptor field layout and the byte-enable helper for the final beat.
package c2h_pkg;

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} c2h_state_e;

  localparam int LEN_LSB    = 0;
  localparam int LEN_W      = 16;
  localparam int TAG_LSB    = 16;
  localparam int TAG_W      = 16;
  // Header beat carries {tag, len} in its low bits, zero-filled above.
  localparam int HDR_W      = LEN_W + TAG_W;
  localparam int BEATS_W    = 13;
  localparam int MAX_KEEP_W = 128;

  // Byte mask for the final data beat: the residual byte count, or a full beat.
  function automatic logic [MAX_KEEP_W-1:0] keep_from_len(input logic [LEN_W-1:0] len,
                                                          input int keep_w);
    int rem;
    logic [MAX_KEEP_W-1:0] mask;
    rem = int'(len) % keep_w;
    if (rem == 0) rem = keep_w;
    mask = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) mask[i] = (i < rem);
    return mask;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered outputs, full throughput,
// and an input ready that depends only on local state.
module axis_skid_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic                  empty
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [PW-1:0] in_pay;
  logic [PW-1:0] skid_p0;
  logic [PW-1:0] pay_p1;
  logic          vld_p0;
  logic          vld_p1;

  assign in_pay   = {in_data, in_keep, in_last};
  assign in_ready = !vld_p0;
  assign empty    = !vld_p0 && !vld_p1;

  // p0: overflow entry, filled only while the output beat is stalled
  // p1: output register driving the stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      skid_p0 <= '0;
      pay_p1  <= '0;
    end else if (out_ready || !vld_p1) begin
      if (vld_p0) begin
        pay_p1 <= skid_p0;
        vld_p1 <= 1'b1;
        vld_p0 <= 1'b0;
      end else begin
        vld_p1 <= in_valid;
        if (in_valid) pay_p1 <= in_pay;
      end
    end else if (in_valid && !vld_p0) begin
      skid_p0 <= in_pay;
      vld_p0  <= 1'b1;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = pay_p1[PW-1 -: DATA_WIDTH];
  assign out_keep  = pay_p1[KEEP_WIDTH:1];
  assign out_last  = pay_p1[0];

endmodule

// File: rtl/c2h_assembler.sv
// Card-to-host assembler: turns descriptor + payload FIFOs into XDMA C2H
// AXI-Stream packets (one header beat, then payload beats).
module c2h_assembler
  import c2h_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int INFO_WIDTH = 32
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  output logic [DATA_WIDTH-1:0] m_axis_c2h_tdata,
  output logic                  m_axis_c2h_tlast,
  output logic                  m_axis_c2h_tvalid,
  input  logic                  m_axis_c2h_tready,
  output logic [KEEP_WIDTH-1:0] m_axis_c2h_tkeep,
  input  logic [INFO_WIDTH-1:0] info_fifo_dout,
  output logic                  info_fifo_rd_en,
  input  logic                  info_fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_fifo_dout,
  output logic                  data_fifo_rd_en,
  input  logic                  data_fifo_empty,
  input  logic                  process_done,
  output logic                  assembly_done,
  output logic [15:0]           pkt_count
);

  c2h_state_e          state, state_nxt;
  logic [BEATS_W-1:0]  beats_left;
  logic [KEEP_WIDTH-1:0] last_keep;

  logic [LEN_W-1:0]      info_len;
  logic [BEATS_W-1:0]    hdr_beats;
  logic [KEEP_WIDTH-1:0] hdr_keep;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic                  in_last;
  logic                  buf_empty;

  assign info_len  = info_fifo_dout[LEN_LSB +: LEN_W];
  assign hdr_beats = BEATS_W'((32'(info_len) + KEEP_WIDTH - 1) / KEEP_WIDTH);
  assign hdr_keep  = KEEP_WIDTH'(keep_from_len(info_len, KEEP_WIDTH));

  always_comb begin
    state_nxt       = state;
    in_valid        = 1'b0;
    in_data         = '0;
    in_keep         = '1;
    in_last         = 1'b0;
    info_fifo_rd_en = 1'b0;
    data_fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (!info_fifo_empty)               state_nxt = HDR;
        else if (process_done && buf_empty) state_nxt = DONE;
      end
      HDR: begin
        in_valid = !info_fifo_empty;
        in_data  = DATA_WIDTH'(info_fifo_dout[HDR_W-1:0]);
        in_last  = (info_len == '0);
        if (in_valid && in_ready) begin
          info_fifo_rd_en = 1'b1;
          state_nxt       = (info_len == '0) ? IDLE : DATA;
        end
      end
      DATA: begin
        in_valid = !data_fifo_empty;
        in_data  = data_fifo_dout;
        in_last  = (beats_left == BEATS_W'(1));
        if (in_last) in_keep = last_keep;
        if (in_valid && in_ready) begin
          data_fifo_rd_en = 1'b1;
          if (in_last) state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) begin
      state      <= IDLE;
      beats_left <= '0;
      last_keep  <= '0;
      pkt_count  <= '0;
    end else begin
      state <= state_nxt;
      if (info_fifo_rd_en) begin
        beats_left <= hdr_beats;
        last_keep  <= hdr_keep;
        if (info_len == '0) pkt_count <= pkt_count + 16'd1;
      end
      if (data_fifo_rd_en) begin
        beats_left <= beats_left - BEATS_W'(1);
        if (beats_left == BEATS_W'(1)) pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  // DONE is only entered once the output buffer has drained.
  assign assembly_done = (state == DONE);

  axis_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_skid (
    .clk      (user_clk),
    .rst_n    (user_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_keep  (in_keep),
    .in_last  (in_last),
    .out_valid(m_axis_c2h_tvalid),
    .out_ready(m_axis_c2h_tready),
    .out_data (m_axis_c2h_tdata),
    .out_keep (m_axis_c2h_tkeep),
    .out_last (m_axis_c2h_tlast),
    .empty    (buf_empty)
  );

endmodule

// File: tb/tb_c2h_assembler.sv
// Self-checking bench for c2h_assembler: FWFT FIFO models, a stream monitor
// and a packet-level reference built from descriptor lengths and tags.
module tb_c2h_assembler;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int IW = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tdata;
  logic          tlast, tvalid;
  logic          tready = 1'b1;
  logic [KW-1:0] tkeep;
  logic [IW-1:0] info_dout = '0;
  logic          info_rd_en;
  logic          info_empty = 1'b1;
  logic [DW-1:0] data_dout = '0;
  logic          data_rd_en;
  logic          data_empty = 1'b1;
  logic          process_done = 1'b0;
  logic          assembly_done;
  logic [15:0]   pkt_count;

  c2h_assembler #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .INFO_WIDTH(IW)) dut (
    .user_clk         (clk),
    .user_rst         (rst_n),
    .m_axis_c2h_tdata (tdata),
    .m_axis_c2h_tlast (tlast),
    .m_axis_c2h_tvalid(tvalid),
    .m_axis_c2h_tready(tready),
    .m_axis_c2h_tkeep (tkeep),
    .info_fifo_dout   (info_dout),
    .info_fifo_rd_en  (info_rd_en),
    .info_fifo_empty  (info_empty),
    .data_fifo_dout   (data_dout),
    .data_fifo_rd_en  (data_rd_en),
    .data_fifo_empty  (data_empty),
    .process_done     (process_done),
    .assembly_done    (assembly_done),
    .pkt_count        (pkt_count)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] iq[$];
  logic [DW-1:0] dq[$];
  beat_t         exp_q[$];
  beat_t         cap_q[$];
  int            info_pops = 0, data_pops = 0, bad_rd = 0, stall_changes = 0;
  logic          starve = 1'b0;
  logic [15:0]   exp_pkts = '0;
  int            vectors = 0, miscompares = 0;

  function automatic void refresh();
    info_empty = (iq.size() == 0);
    info_dout  = info_empty ? '0 : iq[0];
    data_empty = (dq.size() == 0) || starve;
    data_dout  = (dq.size() == 0) ? '0 : dq[0];
  endfunction

  // FWFT FIFO model: rd_en sampled at the edge, pop applied just after it.
  logic ri, rd;
  always begin
    @(posedge clk);
    ri = info_rd_en;
    rd = data_rd_en;
    #1;
    if (ri) begin
      if (iq.size() == 0) bad_rd++; else begin void'(iq.pop_front()); info_pops++; end
    end
    if (rd) begin
      if (dq.size() == 0 || starve) bad_rd++;
      if (dq.size() != 0) begin void'(dq.pop_front()); data_pops++; end
    end
    refresh();
  end

  // Stream monitor: records handshaken beats and any change during a stall.
  logic  prev_stall = 1'b0;
  beat_t hold;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (tvalid !== 1'b1 || tdata !== hold.d || tkeep !== hold.k || tlast !== hold.l))
        stall_changes++;
      if (tvalid && tready) cap_q.push_back('{d: tdata, k: tkeep, l: tlast});
      prev_stall = tvalid && !tready;
      hold = '{d: tdata, k: tkeep, l: tlast};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: header {tag,len}, then ceil(len/16) FIFO words, residual mask on the last.
  task automatic add_pkt(input logic [15:0] len, input logic [15:0] tag);
    int nb, rem;
    beat_t b;
    logic [DW-1:0] w;
    iq.push_back({tag, len});
    b.d = {96'b0, tag, len};
    b.k = '1;
    b.l = (len == 16'd0);
    exp_q.push_back(b);
    nb  = (int'(len) + 15) / 16;
    rem = int'(len) % 16;
    for (int i = 0; i < nb; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      dq.push_back(w);
      b.d = w;
      b.l = (i == nb - 1);
      b.k = (b.l && rem != 0) ? (16'hFFFF >> (16 - rem)) : 16'hFFFF;
      exp_q.push_back(b);
    end
    exp_pkts = exp_pkts + 16'd1;
    refresh();
  endtask

  task automatic wait_beats(input int n, input int mode, output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 2000) begin
      if (cap_q.size() >= n) begin ok = 1'b1; break; end
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      step();
      cyc++;
    end
    tready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid_last: got %b/%b want 0/0", tvalid, tlast);
    end
    vectors++;
    if (tkeep !== '0 || tdata !== '0) begin
      miscompares++; $display("FAIL reset_keep_data: got %h/%h want 0/0", tkeep, tdata);
    end
    vectors++;
    if (info_rd_en !== 1'b0 || data_rd_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_rd_en: got %b/%b want 0/0", info_rd_en, data_rd_en);
    end
    vectors++;
    if (assembly_done !== 1'b0 || pkt_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_done_count: got %b/%0d want 0/0", assembly_done, pkt_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit ok;
    exp_q.delete(); cap_q.delete(); data_pops = 0;
    add_pkt(16'd48, 16'h00A5);
    wait_beats(exp_q.size(), 0, ok);
    vectors++;
    if (!ok || cap_q.size() != 4) begin
      miscompares++; $display("FAIL single_count: got %0d beats want 4", cap_q.size());
    end
    vectors++;
    if (cap_q.size() < 1 || cap_q[0].d[31:0] !== 32'h00A5_0030) begin
      miscompares++; $display("FAIL single_header: got %h want 00a50030", cap_q.size() ? cap_q[0].d[31:0] : 32'h0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i].d !== exp_q[i].d || cap_q[i].k !== exp_q[i].k || cap_q[i].l !== exp_q[i].l) begin
        miscompares++;
        $display("FAIL single_beat%0d: got %h/%h/%b want %h/%h/%b", i, (i < cap_q.size()) ? cap_q[i].d : '0,
                 (i < cap_q.size()) ? cap_q[i].k : '0, (i < cap_q.size()) ? cap_q[i].l : 1'b0, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
    vectors++;
    if (pkt_count !== exp_pkts || data_pops != 3) begin
      miscompares++; $display("FAIL single_pkts_pops: got %0d/%0d want %0d/3", pkt_count, data_pops, exp_pkts);
    end
  endtask

  task automatic test_partial();
    bit ok;
    exp_q.delete(); cap_q.delete(); data_pops = 0;
    add_pkt(16'd20, 16'($urandom));
    dq.push_back({$urandom, $urandom, $urandom, $urandom});
    refresh();
    wait_beats(exp_q.size(), 0, ok);
    vectors++;
    if (!ok || cap_q.size() != 3) begin
      miscompares++; $display("FAIL partial_count: got %0d beats want 3", cap_q.size());
    end
    vectors++;
    if (cap_q.size() < 3 || cap_q[2].k !== 16'h000F || cap_q[2].l !== 1'b1) begin
      miscompares++; $display("FAIL partial_last_keep: got %h/%b want 000f/1", (cap_q.size() > 2) ? cap_q[2].k : 16'h0, (cap_q.size() > 2) ? cap_q[2].l : 1'b0);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i].d !== exp_q[i].d || cap_q[i].k !== exp_q[i].k || cap_q[i].l !== exp_q[i].l) begin
        miscompares++; $display("FAIL partial_beat%0d: got %h want %h", i, (i < cap_q.size()) ? cap_q[i].d : '0, exp_q[i].d);
      end
    end
    vectors++;
    if (data_pops != 2 || dq.size() != 1) begin
      miscompares++; $display("FAIL partial_pops: got %0d pops %0d left want 2 pops 1 left", data_pops, dq.size());
    end
    dq.delete();
    refresh();
  endtask

  task automatic test_zero();
    bit ok;
    exp_q.delete(); cap_q.delete(); data_pops = 0;
    add_pkt(16'd0, 16'd7);
    dq.push_back('1);
    refresh();
    wait_beats(1, 0, ok);
    vectors++;
    if (!ok || cap_q.size() != 1 || cap_q[0].d !== {96'b0, 16'd7, 16'd0} || cap_q[0].l !== 1'b1 || cap_q[0].k !== 16'hFFFF) begin
      miscompares++; $display("FAIL zero_hdr: got %0d beats last=%b want 1 beat last=1", cap_q.size(), (cap_q.size() > 0) ? cap_q[0].l : 1'b0);
    end
    vectors++;
    if (data_pops != 0 || pkt_count !== exp_pkts) begin
      miscompares++; $display("FAIL zero_pops_count: got %0d/%0d want 0/%0d", data_pops, pkt_count, exp_pkts);
    end
    dq.delete();
    refresh();
  endtask

  task automatic test_backpressure();
    bit ok;
    exp_q.delete(); cap_q.delete(); stall_changes = 0;
    add_pkt(16'd128, 16'h0BB0);
    wait_beats(exp_q.size(), 1, ok);
    vectors++;
    if (!ok || cap_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL bp_count: got %0d beats want %0d", cap_q.size(), exp_q.size());
    end
    vectors++;
    if (stall_changes != 0) begin
      miscompares++; $display("FAIL bp_stable: got %0d changes during stall want 0", stall_changes);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i].d !== exp_q[i].d || cap_q[i].k !== exp_q[i].k || cap_q[i].l !== exp_q[i].l) begin
        miscompares++; $display("FAIL bp_beat%0d: got %h want %h", i, (i < cap_q.size()) ? cap_q[i].d : '0, exp_q[i].d);
      end
    end
  endtask

  task automatic test_starvation();
    bit ok;
    int cyc, busy;
    exp_q.delete(); cap_q.delete(); data_pops = 0;
    add_pkt(16'd96, 16'h5AA5);
    cyc = 0;
    while (data_pops < 3 && cyc < 200) begin step(); cyc++; end
    starve = 1'b1;
    refresh();
    busy = 0;
    step();
    repeat (9) begin
      if (tvalid !== 1'b0) busy++;
      step();
    end
    vectors++;
    if (busy != 0 || data_pops != 3) begin
      miscompares++; $display("FAIL starve_gap: got %0d valid cycles %0d pops want 0 and 3", busy, data_pops);
    end
    starve = 1'b0;
    refresh();
    wait_beats(exp_q.size(), 0, ok);
    vectors++;
    if (!ok || cap_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL starve_count: got %0d beats want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i].d !== exp_q[i].d || cap_q[i].k !== exp_q[i].k || cap_q[i].l !== exp_q[i].l) begin
        miscompares++; $display("FAIL starve_beat%0d: got %h/%b want %h/%b", i, (i < cap_q.size()) ? cap_q[i].d : '0,
                                (i < cap_q.size()) ? cap_q[i].l : 1'b0, exp_q[i].d, exp_q[i].l);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_q.delete(); cap_q.delete(); stall_changes = 0;
    for (int p = 0; p < 6; p++) add_pkt(16'($urandom_range(0, 70)), 16'($urandom));
    wait_beats(exp_q.size(), 2, ok);
    vectors++;
    if (!ok || cap_q.size() != exp_q.size() || stall_changes != 0) begin
      miscompares++; $display("FAIL b2b_count: got %0d beats %0d stall changes want %0d and 0", cap_q.size(), stall_changes, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (i >= cap_q.size() || cap_q[i].d !== exp_q[i].d || cap_q[i].k !== exp_q[i].k || cap_q[i].l !== exp_q[i].l) begin
        miscompares++; $display("FAIL b2b_beat%0d: got %h/%h/%b want %h/%h/%b", i, (i < cap_q.size()) ? cap_q[i].d : '0,
                                (i < cap_q.size()) ? cap_q[i].k : '0, (i < cap_q.size()) ? cap_q[i].l : 1'b0, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
    vectors++;
    if (pkt_count !== exp_pkts) begin
      miscompares++; $display("FAIL b2b_pkt_count: got %0d want %0d", pkt_count, exp_pkts);
    end
  endtask

  task automatic test_completion();
    int cyc, early, drops, pops_before;
    exp_q.delete(); cap_q.delete();
    add_pkt(16'd40, 16'h0C01);
    add_pkt(16'd17, 16'h0C02);
    process_done = 1'b1;
    cyc = 0; early = 0;
    while (assembly_done !== 1'b1 && cyc < 500) begin
      tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      step();
      cyc++;
      if (assembly_done === 1'b1 && cap_q.size() != exp_q.size()) early++;
    end
    tready = 1'b1;
    vectors++;
    if (assembly_done !== 1'b1 || early != 0) begin
      miscompares++; $display("FAIL done_timing: got done=%b early=%0d want 1 and 0", assembly_done, early);
    end
    vectors++;
    if (cap_q.size() != exp_q.size() || cap_q[cap_q.size()-1].l !== 1'b1 || pkt_count !== exp_pkts) begin
      miscompares++; $display("FAIL done_drain: got %0d beats count %0d want %0d beats count %0d", cap_q.size(), pkt_count, exp_q.size(), exp_pkts);
    end
    pops_before = info_pops;
    iq.push_back({16'h0DDD, 16'd16});
    refresh();
    drops = 0;
    repeat (10) begin
      step();
      if (assembly_done !== 1'b1 || tvalid !== 1'b0) drops++;
    end
    vectors++;
    if (drops != 0 || info_pops != pops_before) begin
      miscompares++; $display("FAIL done_sticky: got %0d drops %0d pops want 0 and 0", drops, info_pops - pops_before);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (assembly_done !== 1'b0 || pkt_count !== 16'd0) begin
      miscompares++; $display("FAIL rst_done_clear: got %b/%0d want 0/0", assembly_done, pkt_count);
    end
    process_done = 1'b0;
    iq.delete(); dq.delete(); exp_q.delete(); cap_q.delete();
    exp_pkts = '0;
    refresh();
    step();
    rst_n = 1'b1;
    step();
    add_pkt(16'd0, 16'h0E00);
    add_pkt(16'd160, 16'h0E01);
    wait_beats(4, 0, ok);
    vectors++;
    if (!ok || pkt_count !== 16'd1 || tvalid !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_setup: got count %0d valid %b want 1 and 1", pkt_count, tvalid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || pkt_count !== 16'd0 || assembly_done !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_clear: got valid %b last %b count %0d done %b want 0 0 0 0", tvalid, tlast, pkt_count, assembly_done);
    end
    iq.delete(); dq.delete();
    refresh();
    step();
  endtask

  initial begin
    refresh();
    test_reset();
    test_single();
    test_partial();
    test_zero();
    test_backpressure();
    test_starvation();
    test_back_to_back();
    test_completion();
    test_reset_mid();
    vectors++;
    if (bad_rd != 0) begin
      miscompares++; $display("FAIL rd_en_while_empty: got %0d reads want 0", bad_rd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
